// File: rtl/trap_sequencer_if.sv
// Bundle between the trap sequencer and its neighbours (CSR file, decode/hazard unit, PC mux).
// master = environment driving requests and CSR values; slave = the sequencer.
interface trap_sequencer_if;
   logic [31:0] mip;
   logic [31:0] mie;
   logic        MIE;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic        mret_req;
   logic        pipe_ready;
   logic        flush_req;
   logic        int_action;
   logic        ret_action;
   logic        hw_int;
   logic [4:0]  int_code;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        drain_timeout;

   modport master (
      output mip, mie, MIE, mtvec, mepc, exc_req, exc_code, mret_req, pipe_ready,
      input  flush_req, int_action, ret_action, hw_int, int_code, pc_redirect,
             redirect_pc, drain_timeout
   );

   modport slave (
      input  mip, mie, MIE, mtvec, mepc, exc_req, exc_code, mret_req, pipe_ready,
      output flush_req, int_action, ret_action, hw_int, int_code, pc_redirect,
             redirect_pc, drain_timeout
   );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: arbitrate, drain the pipe, strobe the CSR block, redirect the PC.
// Optional feature: define VECTORED_MODE_EN for vectored interrupt targets (mtvec[1:0]==2'b01).
module trap_sequencer #(
   parameter int DRAIN_MAX = 16
) (
   input logic              clk,
   input logic              reset_n,
   trap_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      TAKE   = 3'd2,
      VECTOR = 3'd3,
      RET    = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  drain_cnt;
   logic        trap_kind;
   logic [4:0]  trap_code;
   logic        timeout_flag;

   logic [31:0] eligible;
   logic        pick_valid;
   logic        pick_kind;
   logic [4:0]  pick_code;
   logic        src_live;
   logic        cnt_expired;
   logic [31:0] vec_target;

   assign eligible    = bus.mip & bus.mie & {32{bus.MIE}};
   assign src_live    = eligible[trap_code];
   assign cnt_expired = (drain_cnt == 8'(DRAIN_MAX - 1));

   // Fixed priority among trap sources; mret is handled ahead of this in the FSM.
   always_comb begin
      pick_valid = 1'b0;
      pick_kind  = 1'b0;
      pick_code  = 5'd0;
      if (bus.exc_req) begin
         pick_valid = 1'b1;
         pick_code  = bus.exc_code;
      end else if (eligible[11]) begin
         pick_valid = 1'b1;
         pick_kind  = 1'b1;
         pick_code  = 5'd11;
      end else if (eligible[3]) begin
         pick_valid = 1'b1;
         pick_kind  = 1'b1;
         pick_code  = 5'd3;
      end else if (eligible[7]) begin
         pick_valid = 1'b1;
         pick_kind  = 1'b1;
         pick_code  = 5'd7;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // A vanished interrupt source is dropped before a forced timeout would take it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.mret_req)     state_nxt = RET;
            else if (pick_valid)  state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.pipe_ready)             state_nxt = TAKE;
            else if (trap_kind && !src_live) state_nxt = IDLE;
            else if (cnt_expired)           state_nxt = TAKE;
         end
         TAKE:    state_nxt = VECTOR;
         VECTOR:  state_nxt = IDLE;
         RET:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drain_cnt    <= 8'd0;
         trap_kind    <= 1'b0;
         trap_code    <= 5'd0;
         timeout_flag <= 1'b0;
      end else begin
         if (state == IDLE) begin
            drain_cnt <= 8'd0;
            if (!bus.mret_req && pick_valid) begin
               trap_kind <= pick_kind;
               trap_code <= pick_code;
            end
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 8'd1;
            if (state_nxt == TAKE && !bus.pipe_ready) timeout_flag <= 1'b1;
         end
      end
   end

`ifdef VECTORED_MODE_EN
   always_comb begin
      vec_target = {bus.mtvec[31:2], 2'b00};
      if (trap_kind && bus.mtvec[1:0] == 2'b01)
         vec_target = {bus.mtvec[31:2], 2'b00} + {25'd0, trap_code, 2'b00};
   end
`else
   logic unused_mode_bits;
   assign unused_mode_bits = ^bus.mtvec[1:0];
   assign vec_target       = {bus.mtvec[31:2], 2'b00};
`endif

   // Strobes decode from state only; the target address follows the live CSR values.
   always_comb begin
      bus.flush_req   = (state == DRAIN) || (state == TAKE) || (state == VECTOR);
      bus.int_action  = (state == TAKE);
      bus.hw_int      = (state == TAKE) && trap_kind;
      bus.int_code    = (state == TAKE) ? trap_code : 5'd0;
      bus.ret_action  = (state == RET);
      bus.pc_redirect = (state == VECTOR) || (state == RET);
      bus.redirect_pc = 32'd0;
      if (state == RET)         bus.redirect_pc = bus.mepc;
      else if (state == VECTOR) bus.redirect_pc = vec_target;
   end

   assign bus.drain_timeout = timeout_flag;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised and directed bench for trap_sequencer against an episode-level reference model.
module tb_trap_sequencer;
   localparam int DM = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   trap_sequencer_if bus ();

   trap_sequencer #(.DRAIN_MAX(DM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Reference model: one episode record, aged in cycles since the first drain cycle.
   bit m_busy = 1'b0;
   bit m_ret  = 1'b0;
   bit m_kind = 1'b0;
   int m_code = 0;
   int m_age  = 0;
   bit m_decided = 1'b0;
   int m_take = 0;
   bit m_to   = 1'b0;
   int pri [3] = '{11, 3, 7};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%h expected=0x%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit elig(input int k);
      return bus.mip[k] & bus.mie[k] & bus.MIE;
   endfunction

   function automatic logic [31:0] model_target();
      logic [31:0] t;
      t = bus.mtvec & 32'hFFFF_FFFC;
`ifdef VECTORED_MODE_EN
      if (m_kind && bus.mtvec[1:0] == 2'b01) t = t + 32'(4 * m_code);
`endif
      return t;
   endfunction

   always @(negedge clk) begin : cmp
      bit e_fl, e_ia, e_ra, e_hw, e_pr;
      logic [4:0]  e_code;
      logic [31:0] e_rpc;
      if (checking) begin
         if (!reset_n) begin
            m_busy = 1'b0;
            m_to   = 1'b0;
         end
         e_fl = 0; e_ia = 0; e_ra = 0; e_hw = 0; e_pr = 0;
         e_code = 5'd0; e_rpc = 32'd0;
         if (m_busy && m_ret) begin
            e_ra = 1; e_pr = 1; e_rpc = bus.mepc;
         end else if (m_busy) begin
            e_fl = 1;
            if (m_decided && m_age == m_take) begin
               e_ia = 1; e_hw = m_kind; e_code = 5'(m_code);
            end
            if (m_decided && m_age == m_take + 1) begin
               e_pr = 1; e_rpc = model_target();
            end
         end
         chk("flush_req",     32'(bus.flush_req),     32'(e_fl));
         chk("int_action",    32'(bus.int_action),    32'(e_ia));
         chk("ret_action",    32'(bus.ret_action),    32'(e_ra));
         chk("hw_int",        32'(bus.hw_int),        32'(e_hw));
         chk("int_code",      32'(bus.int_code),      32'(e_code));
         chk("pc_redirect",   32'(bus.pc_redirect),   32'(e_pr));
         chk("redirect_pc",   bus.redirect_pc,        e_rpc);
         chk("drain_timeout", 32'(bus.drain_timeout), 32'(m_to));

         if (reset_n) begin
            if (!m_busy) begin
               m_age = 0; m_decided = 1'b0;
               if (bus.mret_req) begin
                  m_busy = 1; m_ret = 1;
               end else if (bus.exc_req) begin
                  m_busy = 1; m_ret = 0; m_kind = 0; m_code = int'(bus.exc_code);
               end else begin
                  for (int i = 0; i < 3; i++) begin
                     if (!m_busy && elig(pri[i])) begin
                        m_busy = 1; m_ret = 0; m_kind = 1; m_code = pri[i];
                     end
                  end
               end
            end else if (m_ret) begin
               m_busy = 0;
            end else if (!m_decided) begin
               if (bus.pipe_ready) begin
                  m_decided = 1; m_take = m_age + 1;
               end else if (m_kind && !elig(m_code)) begin
                  m_busy = 0;
               end else if (m_age == DM - 1) begin
                  m_decided = 1; m_take = m_age + 1; m_to = 1;
               end
               m_age++;
            end else if (m_age == m_take) begin
               m_age++;
            end else begin
               m_busy = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Entered in the IDLE cycle whose inputs request the trap; leaves in the next IDLE cycle.
   task automatic trap_expect(input string nm, input int code, input bit hw,
                              input logic [31:0] rpc, input logic [31:0] next_mip);
      cyc(); cyc(); neg();
      chk({nm, "_ia"},   32'(bus.int_action), 32'd1);
      chk({nm, "_hw"},   32'(bus.hw_int),     32'(hw));
      chk({nm, "_code"}, 32'(bus.int_code),   32'(code));
      cyc();
      bus.mip = next_mip;
      bus.exc_req = 1'b0;
      neg();
      chk({nm, "_pr"},  32'(bus.pc_redirect), 32'd1);
      chk({nm, "_rpc"}, bus.redirect_pc,      rpc);
      cyc();
   endtask

   initial begin
      logic [31:0] vec_exp;
      bus.mip = 0; bus.mie = 0; bus.MIE = 0; bus.mtvec = 32'h0000_1003; bus.mepc = 0;
      bus.exc_req = 0; bus.exc_code = 0; bus.mret_req = 0; bus.pipe_ready = 0;
      checking = 1'b1;
      repeat (3) cyc();
      neg();
      chk("rst_flush", 32'(bus.flush_req), 32'd0);
      chk("rst_timeout", 32'(bus.drain_timeout), 32'd0);
      cyc();
      reset_n = 1'b1;
      cyc();

      bus.mip = 32'h800; bus.mie = 32'h800; bus.MIE = 1; bus.pipe_ready = 1;
      trap_expect("mei", 11, 1'b1, 32'h0000_1000, 32'h0);

      bus.mip = 32'h888; bus.mie = 32'h888;
      trap_expect("pri11", 11, 1'b1, 32'h0000_1000, 32'h088);
      trap_expect("pri3",  3,  1'b1, 32'h0000_1000, 32'h080);
      trap_expect("pri7",  7,  1'b1, 32'h0000_1000, 32'h000);

      bus.MIE = 0; bus.exc_req = 1; bus.exc_code = 5'd11;
      trap_expect("exc", 11, 1'b0, 32'h0000_1000, 32'h0);
      bus.mip = 32'h80; bus.mie = 32'h80;
      cyc(); neg();
      chk("mie0_flush_a", 32'(bus.flush_req), 32'd0);
      cyc(); neg();
      chk("mie0_flush_b", 32'(bus.flush_req), 32'd0);
      cyc();

      bus.MIE = 1; bus.pipe_ready = 0;
      cyc(); neg();
      chk("abandon_drain", 32'(bus.flush_req), 32'd1);
      cyc();
      bus.mip = 32'h0;
      cyc(); neg();
      chk("abandon_flush", 32'(bus.flush_req), 32'd0);
      chk("abandon_ia", 32'(bus.int_action), 32'd0);
      cyc();

      bus.exc_req = 1; bus.exc_code = 5'd2;
      cyc(); cyc();
      bus.mip = 32'h0; bus.pipe_ready = 1;
      cyc(); neg();
      chk("exc_keep_ia", 32'(bus.int_action), 32'd1);
      chk("exc_keep_code", 32'(bus.int_code), 32'd2);
      cyc();
      bus.exc_req = 0;
      cyc(); cyc(); neg();
      chk("exc_keep_to", 32'(bus.drain_timeout), 32'd0);

      cyc();
      bus.mip = 32'h80; bus.pipe_ready = 0;
      repeat (4) cyc();
      neg();
      chk("to_early_ia", 32'(bus.int_action), 32'd0);
      cyc(); neg();
      chk("to_ia", 32'(bus.int_action), 32'd1);
      chk("to_flag", 32'(bus.drain_timeout), 32'd1);
      cyc();
      bus.mip = 32'h0;
      repeat (3) cyc();
      neg();
      chk("to_sticky", 32'(bus.drain_timeout), 32'd1);

      cyc();
      bus.mip = 32'h80;
      cyc(); cyc();
      reset_n = 1'b0;
      neg();
      chk("midrst_flush", 32'(bus.flush_req), 32'd0);
      chk("midrst_to", 32'(bus.drain_timeout), 32'd0);
      cyc();
      reset_n = 1'b1; bus.mip = 32'h0;
      cyc(); cyc();

      bus.mtvec = 32'h0000_0101; bus.mepc = 32'h2000_0040;
      bus.mret_req = 1; bus.mip = 32'h80; bus.mie = 32'h80; bus.MIE = 0; bus.pipe_ready = 1;
      cyc(); neg();
      chk("mret_ra", 32'(bus.ret_action), 32'd1);
      chk("mret_pr", 32'(bus.pc_redirect), 32'd1);
      chk("mret_rpc", bus.redirect_pc, 32'h2000_0040);
      cyc();
      bus.mret_req = 0; bus.MIE = 1;
`ifdef VECTORED_MODE_EN
      vec_exp = 32'h0000_011C;
`else
      vec_exp = 32'h0000_0100;
`endif
      trap_expect("after_mret", 7, 1'b1, vec_exp, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
         if ($urandom_range(0, 3) == 0) bus.mip = ($urandom & 32'h0000_0888) | ($urandom & 32'h0000_0001);
         if ($urandom_range(0, 7) == 0) bus.mie = ($urandom & 32'h0000_0888) | 32'h0000_0888 & {32{$urandom_range(0, 1) == 1}};
         if ($urandom_range(0, 5) == 0) bus.MIE = ($urandom_range(0, 3) != 0);
         if (bus.exc_req) bus.exc_req = ($urandom_range(0, 3) != 0);
         else begin
            bus.exc_req = ($urandom_range(0, 11) == 0);
            bus.exc_code = 5'($urandom_range(0, 31));
         end
         if (bus.mret_req) bus.mret_req = ($urandom_range(0, 2) != 0);
         else bus.mret_req = ($urandom_range(0, 19) == 0);
         bus.pipe_ready = ($urandom_range(0, 2) == 0);
         bus.mtvec = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
         bus.mepc = $urandom;
      end

      cyc(); neg();
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
